mpf_vtp_page_table_responder: RTL and testbench
===============================================

# mpf_vtp_page_table_responder

Service-side responder for VTP translation ports: accepts line-address translation requests from a translate channel and returns the mapped physical line address, or an error, in request order. Mappings come from a small fully associative page table, loaded through a programming port, supporting 4KB and 2MB pages. The block sits on the service end of a VTP port and serves as a lightweight translation service for simulation and for small AFUs that need no full TLB/page-walker hierarchy.

## Interface
- N_ENTRIES, 16: page table entries (power of 2, 2..64).
- ADDR_WIDTH, 42: line-address width (64-byte lines).
- TAG_WIDTH, 8: opaque request tag returned with the response.
- RSP_FIFO_DEPTH, 4: response buffer entries (power of 2, >=2).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  translation request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_WIDTH  line address.
- req_addrIsVirtual  in  1  0: pass through untranslated.
- req_isSpeculative  in  1  1: a miss is reported as an error rather than counted as fatal.
- req_tag  in  TAG_WIDTH  opaque tag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_addr  out  ADDR_WIDTH  translated line address.
- rsp_error  out  1  translation miss.
- rsp_tag  out  TAG_WIDTH  echoed tag.
- pt_wr_en  in  1  page table write strobe.
- pt_wr_idx  in  log2(N_ENTRIES)  entry index.
- pt_wr_valid  in  1  entry valid bit.
- pt_wr_is_2mb  in  1  page size.
- pt_wr_va  in  ADDR_WIDTH-6  virtual 4KB page number.
- pt_wr_pa  in  ADDR_WIDTH-6  physical 4KB page number.
- hit_cnt, miss_cnt  out  32  saturating counters of virtual requests.
- fatal_miss  out  1  sticky; set on a non-speculative miss.

## Operation
- Page number = addr[ADDR_WIDTH-1:6]. A 4KB entry matches on all page bits. A 2MB entry compares only addr[ADDR_WIDTH-1:15]; the stored va/pa bits [8:0] are ignored.
- Hit: rsp_addr = {pa page bits, req offset bits}, with offset width 6 (4KB) or 15 (2MB). rsp_error=0. hit_cnt increments.
- Multiple matches: the lowest index wins.
- Miss: rsp_addr = req_addr, rsp_error=1, miss_cnt increments. If !req_isSpeculative, fatal_miss sets.
- Non-virtual request: rsp_addr = req_addr, rsp_error=0. Neither counter changes.
- Responses are returned strictly in acceptance order.
- Lookup is a 2-stage pipeline:
  - S1 registers the request and the per-entry match vector.
  - S2 priority-encodes, forms the response, and enqueues it into the response FIFO.
- Credit flow: req_ready = (fifo_count + inflight) < RSP_FIFO_DEPTH, where inflight counts valid S1/S2 stages. The pipeline never stalls, and the FIFO never overflows.
- Page table write: takes effect at the next clock edge. A lookup in the same cycle sees the old contents.
- Counters saturate at 0xFFFF_FFFF.

## Timing
- Reset values:
  - req_ready=0 during reset, 1 in the first cycle after reset.
  - rsp_valid=0; rsp_addr, rsp_error, rsp_tag=0.
  - All entry valid bits=0; counters=0; fatal_miss=0; pipeline and FIFO empty.
- Latency: request accepted at edge N gives rsp_valid at edge N+3 if the FIFO was empty (S1, S2, FIFO registered output). Sustained throughput is 1 per cycle while rsp_ready=1.
- rsp_addr, rsp_error and rsp_tag hold stable while rsp_valid && !rsp_ready.
- Reset asserted mid-operation discards in-flight and buffered responses; no response emerges after reset.
- Simultaneous enqueue and dequeue with a full FIFO is legal; the count is unchanged.

## Structure
- Package mpf_vtp_pkg gains:
  - t_mpf_vtp_pt_entry (valid, is_2mb, va, pa).
  - MPF_VTP_4KB_LINE_OFFSET_BITS=6 and MPF_VTP_2MB_LINE_OFFSET_BITS=15.
- Response buffer: instantiate cci_mpf_prim_fifo_lutram (REGISTER_OUTPUT=1), data = {addr, error, tag}.
- Lookup stages and counters are kept in this module; no other sub-module is needed.

## Test plan
- Load entry 0 with 4KB va=0x1000, pa=0x2000. Request addr 0x40005 -> rsp_addr 0x80005, error 0, at cycle +3. hit_cnt=1.
- Load entry 3 as 2MB, va=0x200, pa=0x600. Request 0x8123 -> rsp_addr 0x18123.
- Speculative request to an unmapped addr 0x12345 -> rsp_error=1, rsp_addr 0x12345, fatal_miss=0. The same request non-speculative -> fatal_miss=1.
- Hold rsp_ready=0 and stream requests: exactly 4 are accepted, then req_ready=0. Release rsp_ready -> 4 responses in order with tags 0..3, and outputs stay stable while stalled.
- Rewrite entry 0 in the same cycle as a lookup hitting it -> the old pa is returned. The next lookup returns the new pa.
- Assert reset with 3 responses buffered -> rsp_valid=0 the next cycle, counters=0, and a prior hit address now misses.

Source files
------------

// File: rtl/mpf_vtp_pkg.sv
// Shared types and constants for the VTP page-table translation service.
package mpf_vtp_pkg;

  localparam int MPF_VTP_4KB_LINE_OFFSET_BITS = 6;
  localparam int MPF_VTP_2MB_LINE_OFFSET_BITS = 15;

  // Line-address width the page-table entry layout is sized for.
  localparam int MPF_VTP_ADDR_WIDTH = 42;
  localparam int MPF_VTP_PAGE_BITS = MPF_VTP_ADDR_WIDTH - MPF_VTP_4KB_LINE_OFFSET_BITS;
  localparam int MPF_VTP_2MB_PAGE_SHIFT =
    MPF_VTP_2MB_LINE_OFFSET_BITS - MPF_VTP_4KB_LINE_OFFSET_BITS;

  typedef struct packed {
    logic                         valid;
    logic                         is_2mb;
    logic [MPF_VTP_PAGE_BITS-1:0] va;
    logic [MPF_VTP_PAGE_BITS-1:0] pa;
  } t_mpf_vtp_pt_entry;

endpackage

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// Small LUTRAM FIFO with an optional registered output stage; count covers
// every stored entry, including the output register.
module cci_mpf_prim_fifo_lutram #(
  parameter int N_DATA_BITS     = 32,
  parameter int N_ENTRIES       = 4,
  parameter bit REGISTER_OUTPUT = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_DATA_BITS-1:0]       enq_data,
  input  logic                         enq_en,
  output logic [$clog2(N_ENTRIES):0]   count,
  output logic [N_DATA_BITS-1:0]       first,
  output logic                         not_empty,
  input  logic                         deq_en
);

  localparam int PTR_W = $clog2(N_ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       mem_count;
  logic                   mem_deq;

  // NOTE: storage is not reset; occupancy is defined by pointers and count only.
  always_ff @(posedge clk) begin
    if (enq_en) mem[wr_ptr] <= enq_data;
  end

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
    end else begin
      if (enq_en)  wr_ptr <= wr_ptr + 1'b1;
      if (mem_deq) rd_ptr <= rd_ptr + 1'b1;
      mem_count <= mem_count + CNT_W'(enq_en) - CNT_W'(mem_deq);
    end
  end

  if (REGISTER_OUTPUT) begin : g_reg_out
    logic                   out_valid;
    logic [N_DATA_BITS-1:0] out_data;

    assign mem_deq = (mem_count != '0) && (!out_valid || deq_en);

    always_ff @(posedge clk) begin
      if (reset) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end else if (mem_deq) begin
        out_valid <= 1'b1;
        out_data  <= mem[rd_ptr];
      end else if (deq_en) begin
        out_valid <= 1'b0;
      end
    end

    assign first     = out_data;
    assign not_empty = out_valid;
    assign count     = mem_count + CNT_W'(out_valid);
  end else begin : g_comb_out
    assign mem_deq   = deq_en && (mem_count != '0);
    assign first     = mem[rd_ptr];
    assign not_empty = (mem_count != '0);
    assign count     = mem_count;
  end

endmodule

// File: rtl/mpf_vtp_page_table_responder.sv
// VTP translation service: fully associative 4KB/2MB page table, two-stage
// lookup, in-order responses through a credit-managed response FIFO.
module mpf_vtp_page_table_responder
  import mpf_vtp_pkg::*;
#(
  parameter int N_ENTRIES      = 16,
  parameter int ADDR_WIDTH     = MPF_VTP_ADDR_WIDTH,
  parameter int TAG_WIDTH      = 8,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [ADDR_WIDTH-1:0]                 req_addr,
  input  logic                                  req_addrIsVirtual,
  input  logic                                  req_isSpeculative,
  input  logic [TAG_WIDTH-1:0]                  req_tag,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [ADDR_WIDTH-1:0]                 rsp_addr,
  output logic                                  rsp_error,
  output logic [TAG_WIDTH-1:0]                  rsp_tag,
  input  logic                                  pt_wr_en,
  input  logic [$clog2(N_ENTRIES)-1:0]          pt_wr_idx,
  input  logic                                  pt_wr_valid,
  input  logic                                  pt_wr_is_2mb,
  input  logic [ADDR_WIDTH-7:0]                 pt_wr_va,
  input  logic [ADDR_WIDTH-7:0]                 pt_wr_pa,
  output logic [31:0]                           hit_cnt,
  output logic [31:0]                           miss_cnt,
  output logic                                  fatal_miss
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int PB    = ADDR_WIDTH - MPF_VTP_4KB_LINE_OFFSET_BITS;
  localparam int SH    = MPF_VTP_2MB_PAGE_SHIFT;
  localparam int CNT_W = $clog2(RSP_FIFO_DEPTH) + 1;
  localparam int RSP_W = ADDR_WIDTH + 1 + TAG_WIDTH;

  t_mpf_vtp_pt_entry pt [N_ENTRIES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ENTRIES; i++) pt[i].valid <= 1'b0;
    end else if (pt_wr_en) begin
      pt[pt_wr_idx] <= '{valid: pt_wr_valid, is_2mb: pt_wr_is_2mb, va: pt_wr_va, pa: pt_wr_pa};
    end
  end

  logic [PB-1:0]        req_page;
  logic [N_ENTRIES-1:0] match;
  logic                 req_fire;

  assign req_page = req_addr[ADDR_WIDTH-1:MPF_VTP_4KB_LINE_OFFSET_BITS];
  assign req_fire = req_valid && req_ready;

  // NOTE: defaults first in every always_comb so no path can infer a latch.
  always_comb begin
    match = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      match[i] = pt[i].valid &&
                 (pt[i].is_2mb ? (pt[i].va[PB-1:SH] == req_page[PB-1:SH])
                               : (pt[i].va == req_page));
    end
  end

  // S1: request, match vector, and the pre-write copy of any entry rewritten
  // on the acceptance edge, so S2 translates against the table the match saw.
  logic                  s1_valid;
  logic                  s1_virt;
  logic                  s1_spec;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [TAG_WIDTH-1:0]  s1_tag;
  logic [N_ENTRIES-1:0]  s1_match;
  logic                  s1_hz;
  logic [IDX_W-1:0]      s1_hz_idx;
  logic                  s1_hz_is_2mb;
  logic [PB-1:0]         s1_hz_pa;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_hz    <= 1'b0;
    end else begin
      s1_valid <= req_fire;
      s1_hz    <= req_fire && pt_wr_en;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      s1_virt      <= req_addrIsVirtual;
      s1_spec      <= req_isSpeculative;
      s1_addr      <= req_addr;
      s1_tag       <= req_tag;
      s1_match     <= match;
      s1_hz_idx    <= pt_wr_idx;
      s1_hz_is_2mb <= pt[pt_wr_idx].is_2mb;
      s1_hz_pa     <= pt[pt_wr_idx].pa;
    end
  end

  logic                  s1_hit;
  logic [IDX_W-1:0]      s1_idx;
  logic                  s1_is_2mb;
  logic [PB-1:0]         s1_pa;
  logic [ADDR_WIDTH-1:0] s1_rsp_addr;

  always_comb begin
    s1_hit = 1'b0;
    s1_idx = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (s1_match[i]) begin
        s1_hit = 1'b1;
        s1_idx = IDX_W'(i);
      end
    end
    if (s1_hz && (s1_hz_idx == s1_idx)) begin
      s1_is_2mb = s1_hz_is_2mb;
      s1_pa     = s1_hz_pa;
    end else begin
      s1_is_2mb = pt[s1_idx].is_2mb;
      s1_pa     = pt[s1_idx].pa;
    end
    s1_rsp_addr = s1_addr;
    if (s1_virt && s1_hit) begin
      s1_rsp_addr = s1_is_2mb
        ? {s1_pa[PB-1:SH], s1_addr[MPF_VTP_2MB_LINE_OFFSET_BITS-1:0]}
        : {s1_pa, s1_addr[MPF_VTP_4KB_LINE_OFFSET_BITS-1:0]};
    end
  end

  // S2: formed response, enqueued on the following edge.
  logic             s2_valid;
  logic [RSP_W-1:0] s2_rsp;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid   <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      fatal_miss <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid && s1_virt) begin
        if (s1_hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
          if (!s1_spec) fatal_miss <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s1_valid) s2_rsp <= {s1_rsp_addr, s1_virt && !s1_hit, s1_tag};
  end

  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] inflight;
  logic [RSP_W-1:0] fifo_first;

  cci_mpf_prim_fifo_lutram #(
    .N_DATA_BITS     (RSP_W),
    .N_ENTRIES       (RSP_FIFO_DEPTH),
    .REGISTER_OUTPUT (1'b1)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .enq_data  (s2_rsp),
    .enq_en    (s2_valid),
    .count     (fifo_count),
    .first     (fifo_first),
    .not_empty (rsp_valid),
    .deq_en    (rsp_valid && rsp_ready)
  );

  // Every stage in flight holds a reserved FIFO slot, so S2 can always enqueue.
  assign inflight  = CNT_W'(s1_valid) + CNT_W'(s2_valid);
  assign req_ready = !reset && ((fifo_count + inflight) < CNT_W'(RSP_FIFO_DEPTH));

  assign {rsp_addr, rsp_error, rsp_tag} = fifo_first;

endmodule

// File: tb/tb_mpf_vtp_page_table_responder.sv
// Randomized and directed bench for mpf_vtp_page_table_responder against a
// behavioural page-table model and an in-order response scoreboard.
module tb_mpf_vtp_page_table_responder;

  localparam int N_ENTRIES      = 16;
  localparam int ADDR_WIDTH     = 42;
  localparam int TAG_WIDTH      = 8;
  localparam int RSP_FIFO_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid, req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_addrIsVirtual, req_isSpeculative;
  logic [TAG_WIDTH-1:0]  req_tag;
  logic                  rsp_valid, rsp_ready;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_error;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic                  pt_wr_en;
  logic [3:0]            pt_wr_idx;
  logic                  pt_wr_valid, pt_wr_is_2mb;
  logic [35:0]           pt_wr_va, pt_wr_pa;
  logic [31:0]           hit_cnt, miss_cnt;
  logic                  fatal_miss;

  always #5 clk = ~clk;

  mpf_vtp_page_table_responder #(
    .N_ENTRIES(N_ENTRIES), .ADDR_WIDTH(ADDR_WIDTH),
    .TAG_WIDTH(TAG_WIDTH), .RSP_FIFO_DEPTH(RSP_FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_addrIsVirtual(req_addrIsVirtual), .req_isSpeculative(req_isSpeculative),
    .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_error(rsp_error), .rsp_tag(rsp_tag),
    .pt_wr_en(pt_wr_en), .pt_wr_idx(pt_wr_idx), .pt_wr_valid(pt_wr_valid),
    .pt_wr_is_2mb(pt_wr_is_2mb), .pt_wr_va(pt_wr_va), .pt_wr_pa(pt_wr_pa),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .fatal_miss(fatal_miss)
  );

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  err;
    logic [TAG_WIDTH-1:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_valid [N_ENTRIES];
  bit          m_2mb   [N_ENTRIES];
  bit [35:0]   m_va    [N_ENTRIES];
  bit [35:0]   m_pa    [N_ENTRIES];
  int unsigned m_hits, m_misses;
  bit          m_fatal;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N_ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_2mb[i] = 1'b0; m_va[i] = '0; m_pa[i] = '0;
    end
    m_hits = 0; m_misses = 0; m_fatal = 1'b0;
    exp_q.delete();
  endfunction

  // Lowest-index valid entry whose page (4KB) or 2MB region covers the address.
  function automatic void model_lookup(input logic [ADDR_WIDTH-1:0] addr, input bit virt,
                                       output logic [ADDR_WIDTH-1:0] ra, output bit hit);
    ra  = addr;
    hit = 1'b0;
    if (!virt) return;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (m_valid[i] && (m_2mb[i] ? ((addr >> 15) == (m_va[i] >> 9))
                                  : ((addr >> 6) == m_va[i]))) begin
        ra  = m_2mb[i] ? (((m_pa[i] >> 9) << 15) | (addr & 42'h7fff))
                       : ((m_pa[i] << 6) | (addr & 42'h3f));
        hit = 1'b1;
        break;
      end
    end
  endfunction

  // One clock: score handshakes visible before the edge, advance the model,
  // then confirm a stalled response held its value across the edge.
  task automatic tick();
    bit                    acc, deq, stall, hit, was_reset;
    logic [ADDR_WIDTH-1:0] ra, p_addr;
    logic                  p_err;
    logic [TAG_WIDTH-1:0]  p_tag;
    exp_t                  e;
    acc       = req_valid && req_ready;
    deq       = rsp_valid && rsp_ready;
    was_reset = reset;
    stall     = rsp_valid && !rsp_ready && !reset;
    p_addr    = rsp_addr; p_err = rsp_error; p_tag = rsp_tag;
    if (deq) begin
      if (exp_q.size() == 0) begin
        check("spurious_rsp", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_addr", rsp_addr, e.addr);
        check("sb_err", rsp_error, e.err);
        check("sb_tag", rsp_tag, e.tag);
      end
    end
    if (acc) begin
      model_lookup(req_addr, req_addrIsVirtual, ra, hit);
      e.addr = ra; e.err = req_addrIsVirtual && !hit; e.tag = req_tag;
      exp_q.push_back(e);
      if (req_addrIsVirtual) begin
        if (hit) m_hits++;
        else begin
          m_misses++;
          if (!req_isSpeculative) m_fatal = 1'b1;
        end
      end
    end
    if (pt_wr_en) begin
      m_valid[pt_wr_idx] = pt_wr_valid; m_2mb[pt_wr_idx] = pt_wr_is_2mb;
      m_va[pt_wr_idx]    = pt_wr_va;    m_pa[pt_wr_idx]  = pt_wr_pa;
    end
    if (was_reset) model_clear();
    @(posedge clk);
    #1;
    if (stall) begin
      check("hold_addr", rsp_addr, p_addr);
      check("hold_err", rsp_error, p_err);
      check("hold_tag", rsp_tag, p_tag);
    end
  endtask

  task automatic pt_write(input int idx, input bit v, input bit is2mb,
                          input logic [35:0] va, input logic [35:0] pa);
    pt_wr_en = 1'b1; pt_wr_idx = 4'(idx); pt_wr_valid = v;
    pt_wr_is_2mb = is2mb; pt_wr_va = va; pt_wr_pa = pa;
    tick();
    pt_wr_en = 1'b0;
  endtask

  task automatic send_one(input string name, input logic [ADDR_WIDTH-1:0] addr,
                          input bit virt, input bit spec, input logic [TAG_WIDTH-1:0] tag,
                          input logic [ADDR_WIDTH-1:0] want_addr, input bit want_err);
    int lat;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = addr; req_addrIsVirtual = virt;
    req_isSpeculative = spec; req_tag = tag;
    check({name, "_ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0; pt_wr_en = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_addr"}, rsp_addr, want_addr);
    check({name, "_err"}, rsp_error, want_err);
    check({name, "_tag"}, rsp_tag, tag);
    tick();
  endtask

  initial begin
    int acc, n;
    logic [35:0] page;
    int unsigned pick;

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_addrIsVirtual = 1'b0;
    req_isSpeculative = 1'b0; req_tag = '0; rsp_ready = 1'b0;
    pt_wr_en = 1'b0; pt_wr_idx = '0; pt_wr_valid = 1'b0; pt_wr_is_2mb = 1'b0;
    pt_wr_va = '0; pt_wr_pa = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_addr", rsp_addr, 0);
    check("rst_rsp_error", rsp_error, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    check("rst_fatal", fatal_miss, 0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", req_ready, 1);

    pt_write(0, 1'b1, 1'b0, 36'h1000, 36'h2000);
    send_one("hit4k", 42'h40005, 1'b1, 1'b0, 8'h11, 42'h80005, 1'b0);
    check("hit4k_cnt", hit_cnt, 1);
    pt_write(3, 1'b1, 1'b1, 36'h200, 36'h600);
    send_one("hit2m", 42'h8123, 1'b1, 1'b0, 8'h22, 42'h18123, 1'b0);
    send_one("spec_miss", 42'h12345, 1'b1, 1'b1, 8'h33, 42'h12345, 1'b1);
    check("spec_fatal", fatal_miss, 0);
    send_one("hard_miss", 42'h12345, 1'b1, 1'b0, 8'h44, 42'h12345, 1'b1);
    check("hard_fatal", fatal_miss, 1);
    send_one("phys", 42'h40005, 1'b0, 1'b0, 8'h55, 42'h40005, 1'b0);
    check("phys_hit_cnt", hit_cnt, 2);
    check("phys_miss_cnt", miss_cnt, 2);

    // Backpressure: credits admit exactly the FIFO depth.
    rsp_ready = 1'b0; acc = 0;
    req_addrIsVirtual = 1'b1; req_isSpeculative = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_valid = 1'b1; req_addr = 42'h40005 + 42'(c); req_tag = 8'(acc);
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    check("bp_accepted", acc, RSP_FIFO_DEPTH);
    check("bp_ready_low", req_ready, 0);
    repeat (3) tick();
    rsp_ready = 1'b1;
    for (int k = 0; k < RSP_FIFO_DEPTH; k++) begin
      n = 0;
      while (!rsp_valid && n < 10) begin tick(); n++; end
      check("bp_order_tag", rsp_tag, k);
      tick();
    end
    check("bp_empty", rsp_valid, 0);

    // Rewrite of an entry on the same edge a lookup is accepted.
    pt_wr_en = 1'b1; pt_wr_idx = 4'd0; pt_wr_valid = 1'b1; pt_wr_is_2mb = 1'b0;
    pt_wr_va = 36'h1000; pt_wr_pa = 36'h3000;
    send_one("hz_old", 42'h40005, 1'b1, 1'b0, 8'h66, 42'h80005, 1'b0);
    send_one("hz_new", 42'h40005, 1'b1, 1'b0, 8'h77, 42'hC0005, 1'b0);

    for (int c = 0; c < 2500; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      pt_wr_en  = ($urandom_range(0, 9) == 0);
      if (pt_wr_en) begin
        pt_wr_idx    = 4'($urandom_range(0, 15));
        pt_wr_valid  = ($urandom_range(0, 4) != 0);
        pt_wr_is_2mb = ($urandom_range(0, 2) == 0);
        pt_wr_va     = 36'($urandom_range(0, 2047));
        pt_wr_pa     = 36'({$urandom, $urandom});
      end
      req_valid = ($urandom_range(0, 2) != 0);
      if (req_valid) begin
        if ($urandom_range(0, 1) == 1) begin
          pick = $urandom_range(0, 15);
          page = m_va[pick];
          if (m_2mb[pick]) page[8:0] = 9'($urandom);
        end else begin
          page = 36'($urandom_range(0, 2047));
        end
        req_addr          = {page, 6'($urandom)};
        req_tag           = 8'($urandom);
        req_addrIsVirtual = ($urandom_range(0, 9) != 0);
        req_isSpeculative = ($urandom_range(0, 1) == 1);
      end
      tick();
    end
    req_valid = 1'b0; pt_wr_en = 1'b0; rsp_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin tick(); n++; end
    check("rand_drained", exp_q.size(), 0);
    check("rand_hit_cnt", hit_cnt, m_hits);
    check("rand_miss_cnt", miss_cnt, m_misses);
    check("rand_fatal", fatal_miss, m_fatal);

    // Reset with responses buffered.
    pt_write(0, 1'b1, 1'b0, 36'h1000, 36'h2000);
    rsp_ready = 1'b0;
    req_addrIsVirtual = 1'b1; req_isSpeculative = 1'b1; req_addr = 42'h40005;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; req_tag = 8'(k);
      tick();
    end
    req_valid = 1'b0;
    repeat (4) tick();
    check("pre_rst_buffered", rsp_valid, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_hit_cnt", hit_cnt, 0);
    check("mid_rst_miss_cnt", miss_cnt, 0);
    check("mid_rst_fatal", fatal_miss, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("no_rsp_after_rst", rsp_valid, 0);
    end
    send_one("post_rst_miss", 42'h40005, 1'b1, 1'b1, 8'h88, 42'h40005, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
